// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : Read-side drain engine for an async FIFO (rd_clk domain). Pops
//            FIFO words, absorbs the one-cycle read latency in a 2-entry skid
//            buffer, presents a valid/ready stream framed into fixed-length
//            bursts, and keeps a running popped-word count.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned BURST_LEN   = 4,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst_n,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_last,
  output logic [COUNT_WIDTH-1:0] words_read
);

  // Index of the final word of a burst; BURST_LEN is limited to 1..255.
  localparam logic [7:0]             LAST_IDX  = 8'(BURST_LEN - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            occupancy;   // valid skid entries, head at slot0
  logic                  inflight;    // a FIFO read was issued last cycle
  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;
  logic [7:0]            burst_cnt;
  logic                  pop;
  logic [2:0]            level;       // occupancy after this cycle's capture/pop
  logic [1:0]            wr_slot;     // slot receiving the in-flight word

  assign pop       = out_valid & out_ready;
  // occupancy + inflight >= pop always holds, since pop needs occupancy >= 1.
  assign level     = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};
  // Only issue a read when the word it returns is guaranteed a free slot.
  // Held low while reset is asserted, even though the registers read zero.
  assign fifo_rd_en = rd_rst_n & ~fifo_empty & (level < 3'd2);
  assign wr_slot   = occupancy - {1'b0, pop};

  assign out_valid = (occupancy != 2'd0);
  assign out_data  = slot0;
  assign out_last  = out_valid & (burst_cnt == LAST_IDX);

  // Track the read issued last cycle and the skid buffer fill level.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      inflight  <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      inflight  <= fifo_rd_en;
      occupancy <= level[1:0];
    end
  end

  // Skid storage: shift on pop, then land the returning word in the first
  // free slot; the capture write deliberately overrides the shift into slot0.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      if (pop) begin
        slot0 <= slot1;
      end
      if (inflight) begin
        if (wr_slot == 2'd0) begin
          slot0 <= fifo_rd_data;
        end else begin
          slot1 <= fifo_rd_data;
        end
      end
    end
  end

  // Burst position: count accepted words, wrapping after the last one.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      burst_cnt <= 8'd0;
    end else if (pop) begin
      if (out_last) begin
        burst_cnt <= 8'd0;
      end else begin
        burst_cnt <= burst_cnt + 8'd1;
      end
    end
  end

  // Running count of FIFO pops, free-running modulo 2^COUNT_WIDTH.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      words_read <= '0;
    end else if (fifo_rd_en) begin
      words_read <= words_read + COUNT_ONE;
    end
  end

  // A capture into a full buffer that is not draining would lose a word.
  always @(posedge rd_clk) begin
    if (rd_rst_n) begin
      assert (!(inflight && (occupancy == 2'd2) && !pop));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_reader
// Purpose  : Directed self-checking bench for fifo_stream_reader, with a
//            behavioural FIFO read port feeding each instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

  logic       clk;
  logic       rd_rst_n;

  // Instance 1: default parameters (BURST_LEN=4, COUNT_WIDTH=16)
  logic        empty1;
  logic        rd_en1;
  logic [7:0]  rdata1;
  logic        valid1;
  logic        ready1;
  logic [7:0]  data1;
  logic        last1;
  logic [15:0] wcnt1;

  // Instance 2: BURST_LEN=1, COUNT_WIDTH=4
  logic        empty2;
  logic        rd_en2;
  logic [7:0]  rdata2;
  logic        valid2;
  logic        ready2;
  logic [7:0]  data2;
  logic        last2;
  logic [3:0]  wcnt2;

  int checks = 0;
  int errors = 0;

  // Behavioural FIFO storage and pointers
  logic [7:0] mem1 [0:63];
  logic [7:0] mem2 [0:63];
  int wr1 = 0;
  int rd1 = 0;
  int wr2 = 0;
  int rd2 = 0;

  assign empty1 = (wr1 == rd1);
  assign empty2 = (wr2 == rd2);

  fifo_stream_reader dut (
    .rd_clk       (clk),
    .rd_rst_n     (rd_rst_n),
    .fifo_empty   (empty1),
    .fifo_rd_en   (rd_en1),
    .fifo_rd_data (rdata1),
    .out_valid    (valid1),
    .out_ready    (ready1),
    .out_data     (data1),
    .out_last     (last1),
    .words_read   (wcnt1)
  );

  fifo_stream_reader #(
    .DATA_WIDTH  (8),
    .BURST_LEN   (1),
    .COUNT_WIDTH (4)
  ) dut2 (
    .rd_clk       (clk),
    .rd_rst_n     (rd_rst_n),
    .fifo_empty   (empty2),
    .fifo_rd_en   (rd_en2),
    .fifo_rd_data (rdata2),
    .out_valid    (valid2),
    .out_ready    (ready2),
    .out_data     (data2),
    .out_last     (last2),
    .words_read   (wcnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO read ports: data is valid the cycle after a sampled read enable.
  always @(posedge clk) begin
    if (rd_en1) begin
      rdata1 <= mem1[rd1 % 64];
      rd1    <= rd1 + 1;
    end
    if (rd_en2) begin
      rdata2 <= mem2[rd2 % 64];
      rd2    <= rd2 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [7:0] d);
    mem1[wr1 % 64] = d;
    wr1++;
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  logic       pat [0:3];
  logic       prev_stall;
  logic [7:0] prev_data;
  logic       prev_last;
  int         idx;
  int         got;

  initial begin
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    rd_rst_n = 1'b0;
    ready1   = 1'b1;
    ready2   = 1'b1;
    rdata1   = '0;
    rdata2   = '0;

    // Reset state
    tick;
    check("rst_valid", 32'(valid1), 32'd0);
    check("rst_last",  32'(last1),  32'd0);
    check("rst_data",  32'(data1),  32'd0);
    check("rst_wcnt",  32'(wcnt1),  32'd0);
    check("rst_rd_en", 32'(rd_en1), 32'd0);
    @(negedge clk);
    rd_rst_n = 1'b1;
    #1;

    // Test 1: empty FIFO for 20 cycles -> nothing happens
    for (int i = 0; i < 20; i++) begin
      check("idle_rd_en", 32'(rd_en1), 32'd0);
      check("idle_valid", 32'(valid1), 32'd0);
      check("idle_wcnt",  32'(wcnt1),  32'd0);
      tick;
    end

    // Test 2: 8 words, ready held high, full-rate streaming
    for (int i = 0; i < 8; i++) push1(8'h11 + 8'(i));
    #1;
    check("t2_first_rd_en", 32'(rd_en1), 32'd1);
    check("t2_valid_c0",    32'(valid1), 32'd0);
    tick;
    check("t2_valid_c1",    32'(valid1), 32'd0);
    tick;
    for (int i = 0; i < 8; i++) begin
      check("t2_valid", 32'(valid1), 32'd1);
      check("t2_data",  32'(data1),  32'h11 + 32'(i));
      check("t2_last",  32'(last1),  (i == 3 || i == 7) ? 32'd1 : 32'd0);
      tick;
    end
    check("t2_wcnt",      32'(wcnt1),  32'd8);
    check("t2_rd_en_end", 32'(rd_en1), 32'd0);
    check("t2_valid_end", 32'(valid1), 32'd0);

    // Test 3: same words, ready toggling 1,0,0,1
    for (int i = 0; i < 8; i++) push1(8'h11 + 8'(i));
    idx        = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    for (int cyc = 0; cyc < 80 && idx < 8; cyc++) begin
      ready1 = pat[cyc % 4];
      #1;
      if (prev_stall) begin
        check("t3_hold_valid", 32'(valid1), 32'd1);
        check("t3_hold_data",  32'(data1),  32'(prev_data));
        check("t3_hold_last",  32'(last1),  32'(prev_last));
      end
      check("t3_occ_max", 32'(dut.occupancy != 2'd3), 32'd1);
      if (dut.occupancy == 2'd2 && !ready1) check("t3_rd_en_full", 32'(rd_en1), 32'd0);
      if (valid1 && ready1) begin
        check("t3_data", 32'(data1), 32'h11 + 32'(idx));
        check("t3_last", 32'(last1), (idx % 4 == 3) ? 32'd1 : 32'd0);
        idx++;
      end
      prev_stall = valid1 & ~ready1;
      prev_data  = data1;
      prev_last  = last1;
      @(negedge clk);
    end
    check("t3_all_words", 32'(idx), 32'd8);
    ready1 = 1'b1;
    tick;
    check("t3_wcnt",  32'(wcnt1),  32'd16);
    check("t3_valid", 32'(valid1), 32'd0);

    // Test 4: single word 0xA5
    push1(8'hA5);
    #1;
    check("t4_rd_en_pulse", 32'(rd_en1), 32'd1);
    check("t4_burst0",      32'(dut.burst_cnt), 32'd0);
    tick;
    check("t4_rd_en_off",   32'(rd_en1), 32'd0);
    check("t4_valid_c1",    32'(valid1), 32'd0);
    tick;
    check("t4_valid",       32'(valid1), 32'd1);
    check("t4_data",        32'(data1),  32'hA5);
    check("t4_last",        32'(last1),  32'd0);
    tick;
    check("t4_burst1",      32'(dut.burst_cnt), 32'd1);
    check("t4_valid_end",   32'(valid1), 32'd0);
    check("t4_rd_en_end",   32'(rd_en1), 32'd0);
    check("t4_wcnt",        32'(wcnt1),  32'd17);

    // Test 5: asynchronous reset with two words buffered
    ready1 = 1'b0;
    push1(8'hB1); push1(8'hB2); push1(8'hB3); push1(8'hB4);
    tick;
    tick;
    tick;
    check("t5_occ2",   32'(dut.occupancy), 32'd2);
    check("t5_valid",  32'(valid1), 32'd1);
    check("t5_data",   32'(data1),  32'hB1);
    check("t5_rd_en_full", 32'(rd_en1), 32'd0);
    rd_rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(valid1), 32'd0);
    check("t5_rst_data",  32'(data1),  32'd0);
    check("t5_rst_wcnt",  32'(wcnt1),  32'd0);
    check("t5_rst_rd_en", 32'(rd_en1), 32'd0);
    @(negedge clk);
    rd_rst_n = 1'b1;
    ready1   = 1'b1;
    #1;
    check("t5_rel_wcnt",  32'(wcnt1),  32'd0);
    check("t5_rel_burst", 32'(dut.burst_cnt), 32'd0);
    check("t5_rel_rd_en", 32'(rd_en1), 32'd1);
    tick;
    check("t5_valid_c1",  32'(valid1), 32'd0);
    tick;
    check("t5_b3_valid",  32'(valid1), 32'd1);
    check("t5_b3_data",   32'(data1),  32'hB3);
    check("t5_b3_burst",  32'(dut.burst_cnt), 32'd0);
    check("t5_b3_last",   32'(last1),  32'd0);
    tick;
    check("t5_b4_data",   32'(data1),  32'hB4);
    check("t5_b4_burst",  32'(dut.burst_cnt), 32'd1);
    tick;
    check("t5_end_valid", 32'(valid1), 32'd0);
    check("t5_end_wcnt",  32'(wcnt1),  32'd2);

    // Test 6: COUNT_WIDTH=4, BURST_LEN=1, 18 words -> counter wraps to 2
    check("t6_wcnt_start", 32'(wcnt2), 32'd0);
    for (int i = 0; i < 18; i++) mem2[i] = 8'h40 + 8'(i);
    wr2 = 18;
    got = 0;
    #1;
    for (int cyc = 0; cyc < 60 && got < 18; cyc++) begin
      check("t6_no_rd_when_empty", 32'(rd_en2 & empty2), 32'd0);
      if (valid2) begin
        check("t6_last", 32'(last2), 32'd1);
        check("t6_data", 32'(data2), 32'h40 + 32'(got));
        got++;
      end
      tick;
    end
    check("t6_all_words", 32'(got),   32'd18);
    check("t6_wcnt_wrap", 32'(wcnt2), 32'd2);
    check("t6_valid_end", 32'(valid2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
